// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared fetch-stage types, state encoding and defaults
package if_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;
    localparam int          ENTRY_W          = 65;

    // One buffered fetch: instruction word, its PC, predictor decision.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        pred;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - fetched-instruction buffer between fetch and decode
//
// Ports:
//   clk, reset_n      clock, synchronous active-low reset
//   flush_i           empty the buffer this cycle (overrides push/pop)
//   push_i, push_data_i  write one entry
//   pop_i             drop the head entry (caller only pops when not empty)
//   count_o           number of valid entries
//   empty_o           no valid entries
//   head_o            head entry, all zeros while empty
module fetch_fifo
    import if_stage_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush_i,
    input  logic               push_i,
    input  logic [ENTRY_W-1:0] push_data_i,
    input  logic               pop_i,
    output logic [CNT_W-1:0]   count_o,
    output logic               empty_o,
    output logic [ENTRY_W-1:0] head_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // DEPTH is a power of two, so pointer increments wrap on their own.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked while the buffer is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with single outstanding request
//
// Ports:
//   clk, reset_n                         clock, synchronous active-low reset
//   imem_req_valid_o/ready_i, imem_addr_o fetch request to instruction memory
//   imem_rsp_valid_i, imem_rsp_data_i     returned instruction word
//   pred_instr_o, pred_pc_o               word and PC offered to the predictor
//   br_pred_i, new_pc_pred_i              predictor answer, same cycle
//   redirect_i, redirect_pc_i             restart fetch from execute
//   if_valid_o/if_ready_i                 decode handshake
//   if_instr_o, if_pc_o, if_pred_taken_o  head entry towards decode
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    output logic [31:0] pred_instr_o,
    output logic [31:0] pred_pc_o,
    input  logic        br_pred_i,
    input  logic [31:0] new_pc_pred_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        if_valid_o,
    input  logic        if_ready_i,
    output logic [31:0] if_instr_o,
    output logic [31:0] if_pc_o,
    output logic        if_pred_taken_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic             req_hs;
    logic             fifo_push, fifo_pop, fifo_flush, fifo_empty;
    logic [CNT_W-1:0] fifo_count, cnt_after_pop, cnt_after_push;
    fetch_entry_t     push_entry, head_entry;
    logic [ENTRY_W-1:0] head_bits;

    // State resets to REQ, but the request is held low until reset is released.
    assign imem_req_valid_o = reset_n && (state_q == REQ);
    assign imem_addr_o      = pc_q;
    assign req_hs           = imem_req_valid_o && imem_req_ready_i;

    // While waiting, pc_q still holds the address of the outstanding request.
    assign pred_instr_o = imem_rsp_data_i;
    assign pred_pc_o    = pc_q;

    assign if_valid_o     = !fifo_empty;
    assign fifo_pop       = if_valid_o && if_ready_i;
    assign cnt_after_pop  = fifo_count - CNT_W'(fifo_pop);
    assign cnt_after_push = cnt_after_pop + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
        push_entry = '{instr: imem_rsp_data_i, pc: pc_q, pred: br_pred_i};

        case (state_q)
            IDLE: begin
                if (cnt_after_pop < CNT_W'(FIFO_DEPTH)) state_d = REQ;
            end
            REQ: begin
                if (req_hs) state_d = WAIT;
            end
            WAIT: begin
                if (imem_rsp_valid_i) begin
                    fifo_push = 1'b1;
                    pc_d      = br_pred_i ? word_align(new_pc_pred_i) : pc_q + 32'd4;
                    state_d   = (cnt_after_push < CNT_W'(FIFO_DEPTH)) ? REQ : IDLE;
                end
            end
            DROP: begin
                if (imem_rsp_valid_i) state_d = REQ;
            end
            default: state_d = REQ;
        endcase

        // Redirect overrides everything above. Any request already accepted by
        // memory must have its response swallowed in DROP before refetching.
        if (redirect_i) begin
            fifo_flush = 1'b1;
            fifo_push  = 1'b0;
            pc_d       = word_align(redirect_pc_i);
            case (state_q)
                WAIT:    state_d = imem_rsp_valid_i ? REQ : DROP;
                REQ:     state_d = req_hs ? DROP : REQ;
                // A stale response arriving with the redirect still retires the
                // outstanding request; staying in DROP would then never leave.
                DROP:    state_d = imem_rsp_valid_i ? REQ : DROP;
                default: state_d = REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fetch_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush_i     (fifo_flush),
        .push_i      (fifo_push),
        .push_data_i (push_entry),
        .pop_i       (fifo_pop),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty),
        .head_o      (head_bits)
    );

    assign head_entry      = fetch_entry_t'(head_bits);
    assign if_instr_o      = head_entry.instr;
    assign if_pc_o         = head_entry.pc;
    assign if_pred_taken_o = head_entry.pred;

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 Parameter FIFO_DEPTH, default 2, number of fetched-instruction buffer entries; power of two, >= 2.
REQ-003 clk  input  1  clock, all state updates on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 imem_req_valid_o  output  1  fetch request valid.
REQ-006 imem_req_ready_i  input  1  memory accepts the request this cycle.
REQ-007 imem_addr_o  output  32  fetch address, word aligned.
REQ-008 imem_rsp_valid_i  input  1  instruction word returned this cycle.
REQ-009 imem_rsp_data_i  input  32  returned instruction word.
REQ-010 pred_instr_o  output  32  instruction sent to the branch predictor; equals imem_rsp_data_i.
REQ-011 pred_pc_o  output  32  PC of pred_instr_o.
REQ-012 br_pred_i  input  1  predictor taken decision for pred_instr_o, same cycle.
REQ-013 new_pc_pred_i  input  32  predicted target for pred_instr_o, same cycle.
REQ-014 redirect_i  input  1  misprediction/redirect from execute.
REQ-015 redirect_pc_i  input  32  correct next PC when redirect_i is high.
REQ-016 if_valid_o  output  1  decode-side entry valid.
REQ-017 if_ready_i  input  1  decode accepts the entry.
REQ-018 if_instr_o  output  32  instruction of head entry.
REQ-019 if_pc_o  output  32  PC of head entry.
REQ-020 if_pred_taken_o  output  1  prediction recorded with head entry.

Function
REQ-021 FSM states SHALL be IDLE, REQ, WAIT, DROP; at most one request outstanding.
REQ-022 IDLE: go to REQ when FIFO count < FIFO_DEPTH (counted after this cycle's pop); else stay.
REQ-023 REQ: imem_req_valid_o=1, imem_addr_o=pc; on valid&ready go to WAIT; else stay.
REQ-024 WAIT: imem_req_valid_o=0; on imem_rsp_valid_i push {rsp_data, pc, br_pred_i} into FIFO, pc <= br_pred_i ? new_pc_pred_i : pc+4, then go REQ if space remains after push/pop, else IDLE.
REQ-025 Predictor outputs (br_pred_i, new_pc_pred_i) SHALL be sampled only in the response cycle; zero added latency: response at cycle N -> next request valid at N+1.
REQ-026 PC arithmetic SHALL be 32-bit modulo; pc+4 from 32'hFFFF_FFFC wraps to 0.
REQ-027 redirect_i SHALL win over every other event: FIFO flushed (count 0), pc <= {redirect_pc_i[31:2],2'b00}, if_valid_o=0 next cycle.
REQ-028 Redirect in WAIT without same-cycle rsp, or in REQ with same-cycle req handshake: go DROP.
REQ-029 Redirect in WAIT with same-cycle rsp: response discarded, go REQ.
REQ-030 Redirect in IDLE or REQ without handshake: go REQ; address may change while valid is held.
REQ-031 DROP: imem_req_valid_o=0; discard next response, then go REQ; redirect in DROP updates pc, stays DROP.
REQ-032 FIFO: if_valid_o = not empty; pop on if_valid_o & if_ready_i; simultaneous push and pop when full is impossible by REQ-022, when partially full count unchanged.
REQ-033 Pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-034 During reset: state=REQ on exit, pc=RESET_PC, FIFO empty, imem_req_valid_o=0, if_valid_o=0, if_instr_o/if_pc_o=0, if_pred_taken_o=0.
REQ-035 First cycle after reset_n rises: imem_req_valid_o=1, imem_addr_o=RESET_PC.
REQ-036 Reset mid-transaction SHALL abandon the outstanding request; a late response after reset is not guaranteed to be discarded (memory reset together).

Structure
REQ-037 FSM state encoding and RESET_PC default SHALL live in the shared parameters include.
REQ-038 Buffer SHALL be sub-module fetch_fifo (data 65 bits: instr, pc, pred).

Verification
REQ-039 Reset, ready=1, rsp 1 cycle later, non-branch words -> addresses 0,4,8,...; decode receives pc 0,4,8 in order.
REQ-040 Response at pc 0x10 with br_pred_i=1, new_pc_pred_i=0x40 -> next imem_addr_o=0x40, if_pred_taken_o=1 for pc 0x10.
REQ-041 if_ready_i=0 -> exactly 2 entries buffered, FSM in IDLE, no request; if_ready_i=1 -> fetch resumes next cycle.
REQ-042 redirect_i with redirect_pc_i=0x203 while WAIT -> stale response dropped, next request addr 0x200, FIFO empty.
REQ-043 redirect_i same cycle as rsp and pop -> nothing pushed, if_valid_o=0 next cycle, request to redirect PC.
REQ-044 pc=0xFFFF_FFFC non-branch -> next address 0x0000_0000.
